instruction_fetch: RTL and testbench

//  Stage in front of the decoder. Fetches 32-bit ARM instructions from the

---
 rtl/instruction_fetch.sv | 106 ++++++++++
 tb/tb_instruction_fetch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: prefetches 32-bit words into a small queue and
// presents one instruction per cycle to decode, with NOP injection and redirect handling.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'hE320F000;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state, state_next;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic          ack_seen, push, pop, hold_req, issue;

  always_comb begin
    ack_seen      = mem_req_o & mem_ack_i;
    hold_req      = mem_req_o & ~mem_ack_i;
    push          = ack_seen && (state == RUN) && !branch_i;
    pop           = !branch_i && !stall_i && (count != '0);
    state_next    = state;
    count_next    = count;
    fetch_pc_next = fetch_pc;
    case (state)
      RUN:     if (branch_i && hold_req) state_next = DRAIN;
      DRAIN:   if (ack_seen) state_next = RUN;
      default: state_next = RUN;
    endcase
    if (branch_i) begin
      count_next    = '0;
      fetch_pc_next = {branch_target_i[31:2], 2'b00};
    end else begin
      count_next = count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) fetch_pc_next = fetch_pc + 32'd4;
    end
    // A new request reserves its queue slot now, so the later push cannot overflow.
    issue = !hold_req && (state_next == RUN) && (count_next < (AW+1)'(DEPTH));
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      mem_req_o     <= 1'b0;
      mem_addr_o    <= RESET_PC;
      fetch_pc      <= RESET_PC;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      instr_o       <= NOP;
      instr_valid_o <= 1'b0;
      pc_o          <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      count    <= count_next;
      if (!hold_req) begin
        mem_req_o <= issue;
        if (issue) mem_addr_o <= fetch_pc_next;
      end
      if (branch_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (branch_i || (!stall_i && count == '0)) begin
        instr_o       <= NOP;
        instr_valid_o <= 1'b0;
        pc_o          <= '0;
      end else if (pop) begin
        instr_o       <= q_instr[rd_ptr];
        instr_valid_o <= 1'b1;
        pc_o          <= q_pc[rd_ptr];
      end
    end
  end

  // Queue storage
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= mem_rdata_i;
      q_pc[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table of per-cycle vectors plus
// hand-written redirect and reset sequences.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'hE320F000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        branch;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_o       (mem_req),
    .mem_addr_o      (mem_addr),
    .mem_ack_i       (mem_ack),
    .mem_rdata_i     (mem_rdata),
    .stall_i         (stall),
    .branch_i        (branch),
    .branch_target_i (branch_target),
    .instr_o         (instr),
    .instr_valid_o   (instr_valid),
    .pc_o            (pc)
  );

  typedef struct {
    logic        stall;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(logic s, logic a, logic r, logic [31:0] ad,
                              logic v, logic [31:0] in, logic [31:0] p);
    vec_t x;
    x.stall = s; x.ack = a; x.exp_req = r; x.exp_addr = ad;
    x.exp_valid = v; x.exp_instr = in; x.exp_pc = p;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic r, input logic [31:0] ad,
                           input logic v, input logic [31:0] in, input logic [31:0] p);
    check({tag, ".req"},   {31'd0, mem_req}, {31'd0, r});
    check({tag, ".addr"},  mem_addr, ad);
    check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
    check({tag, ".instr"}, instr, in);
    check({tag, ".pc"},    pc, p);
  endtask

  // Memory returns the word equal to its address.
  task automatic step();
    mem_rdata = mem_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    check_all("reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; stall = 1'b0;
    branch = 1'b0; branch_target = '0;

    tbl[0]  = mk(0, 1, 1, 32'h00, 0, NOP,    32'h00);
    tbl[1]  = mk(0, 1, 1, 32'h04, 0, NOP,    32'h00);
    tbl[2]  = mk(0, 1, 1, 32'h08, 1, 32'h00, 32'h00);
    tbl[3]  = mk(0, 1, 1, 32'h0C, 1, 32'h04, 32'h04);
    tbl[4]  = mk(0, 1, 1, 32'h10, 1, 32'h08, 32'h08);
    tbl[5]  = mk(0, 0, 1, 32'h10, 1, 32'h0C, 32'h0C);
    for (int i = 6; i <= 9; i++) tbl[i] = mk(0, 0, 1, 32'h10, 0, NOP, 32'h00);
    tbl[10] = mk(0, 1, 1, 32'h14, 0, NOP,    32'h00);
    tbl[11] = mk(0, 1, 1, 32'h18, 1, 32'h10, 32'h10);
    tbl[12] = mk(1, 1, 1, 32'h1C, 1, 32'h10, 32'h10);
    tbl[13] = mk(1, 1, 1, 32'h20, 1, 32'h10, 32'h10);
    for (int i = 14; i <= 21; i++) tbl[i] = mk(1, 1, 0, 32'h20, 1, 32'h10, 32'h10);
    tbl[22] = mk(0, 1, 1, 32'h24, 1, 32'h14, 32'h14);
    tbl[23] = mk(0, 1, 1, 32'h28, 1, 32'h18, 32'h18);
    tbl[24] = mk(0, 1, 1, 32'h2C, 1, 32'h1C, 32'h1C);
    tbl[25] = mk(0, 1, 1, 32'h30, 1, 32'h20, 32'h20);
    tbl[26] = mk(0, 1, 1, 32'h34, 1, 32'h24, 32'h24);

    do_reset();
    for (int i = 0; i < 27; i++) begin
      stall   = tbl[i].stall;
      mem_ack = tbl[i].ack;
      step();
      check_all($sformatf("vec%0d", i), tbl[i].exp_req, tbl[i].exp_addr,
                tbl[i].exp_valid, tbl[i].exp_instr, tbl[i].exp_pc);
    end

    // Redirect while the request to 0x20 waits three cycles for its ack.
    stall = 1'b0;
    do_reset();
    mem_ack = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check_all("pre_br", 1'b1, 32'h20, 1'b1, 32'h18, 32'h18);
    mem_ack = 1'b0; branch = 1'b1; branch_target = 32'h103;
    step();
    check_all("br_pend", 1'b1, 32'h20, 1'b0, NOP, 32'h0);
    branch = 1'b0;
    step();
    check_all("drain1", 1'b1, 32'h20, 1'b0, NOP, 32'h0);
    step();
    check_all("drain2", 1'b1, 32'h20, 1'b0, NOP, 32'h0);
    mem_ack = 1'b1;
    step();
    check_all("drain_ack", 1'b1, 32'h100, 1'b0, NOP, 32'h0);
    step();
    check_all("tgt_push", 1'b1, 32'h104, 1'b0, NOP, 32'h0);
    step();
    check_all("tgt_out", 1'b1, 32'h108, 1'b1, 32'h100, 32'h100);

    // Redirect coinciding with an ack (and a stall, which it overrides).
    branch = 1'b1; stall = 1'b1; branch_target = 32'h40;
    step();
    check_all("br_ack", 1'b1, 32'h40, 1'b0, NOP, 32'h0);
    branch = 1'b0; stall = 1'b0;
    step();
    check_all("br_ack2", 1'b1, 32'h44, 1'b0, NOP, 32'h0);
    step();
    check_all("br_ack3", 1'b1, 32'h48, 1'b1, 32'h40, 32'h40);

    // Build occupancy, enter DRAIN, redirect again, then reset from DRAIN.
    stall = 1'b1;
    step();
    step();
    check_all("fill", 1'b1, 32'h50, 1'b1, 32'h40, 32'h40);
    mem_ack = 1'b0; branch = 1'b1; branch_target = 32'h100;
    step();
    check_all("to_drain", 1'b1, 32'h50, 1'b0, NOP, 32'h0);
    branch_target = 32'h200;
    step();
    check_all("br_in_drain", 1'b1, 32'h50, 1'b0, NOP, 32'h0);
    branch = 1'b0; stall = 1'b0; rst = 1'b1;
    step();
    check_all("rst_drain", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
    rst = 1'b0;
    step();
    check_all("post_rst", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
    mem_ack = 1'b1;
    step();
    check_all("post_rst2", 1'b1, 32'h4, 1'b0, NOP, 32'h0);
    step();
    check_all("post_rst3", 1'b1, 32'h8, 1'b1, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
